// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// The master issues operands with start; the slave reports busy/done and results.
interface div_unit_if;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring divider: one quotient bit per cycle on operand magnitudes.
// Signs are reapplied at commit, and divide-by-zero results are substituted there.
module div_unit (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  count;
  logic [31:0] dvd_shift;
  logic [31:0] dvs_mag;
  logic [31:0] rem_acc;
  logic [31:0] quo_acc;
  logic [31:0] raw_dividend;
  logic        q_neg;
  logic        r_neg;
  logic        div_zero;
  logic [31:0] q_out;
  logic [31:0] r_out;

  logic        accept;
  logic        last_step;
  logic [31:0] dvd_mag_in;
  logic [31:0] dvs_mag_in;
  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  assign accept     = bus.start && (state != S_CALC);
  assign last_step  = (state == S_CALC) && (count == 5'd31);
  assign dvd_mag_in = (bus.is_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign dvs_mag_in = (bus.is_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CALC;
      S_CALC:  if (count == 5'd31) state_next = S_DONE;
      S_DONE:  state_next = accept ? S_CALC : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // The partial remainder stays below the divisor magnitude, so a 33-bit trial
  // subtraction is enough to tell whether the shifted value can absorb it.
  always_comb begin
    shifted  = {rem_acc, dvd_shift[31]};
    trial    = shifted - {1'b0, dvs_mag};
    rem_step = shifted[31:0];
    quo_step = {quo_acc[30:0], 1'b0};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo_acc[30:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= 5'd0;
      dvd_shift    <= 32'd0;
      dvs_mag      <= 32'd0;
      rem_acc      <= 32'd0;
      quo_acc      <= 32'd0;
      raw_dividend <= 32'd0;
      q_neg        <= 1'b0;
      r_neg        <= 1'b0;
      div_zero     <= 1'b0;
      q_out        <= 32'd0;
      r_out        <= 32'd0;
    end else if (accept) begin
      count        <= 5'd0;
      dvd_shift    <= dvd_mag_in;
      dvs_mag      <= dvs_mag_in;
      rem_acc      <= 32'd0;
      quo_acc      <= 32'd0;
      raw_dividend <= bus.dividend;
      q_neg        <= bus.is_signed && (bus.dividend[31] ^ bus.divisor[31]);
      r_neg        <= bus.is_signed && bus.dividend[31];
      div_zero     <= (bus.divisor == 32'd0);
    end else if (state == S_CALC) begin
      count     <= count + 5'd1;
      dvd_shift <= {dvd_shift[30:0], 1'b0};
      rem_acc   <= rem_step;
      quo_acc   <= quo_step;
      if (last_step) begin
        q_out <= div_zero ? 32'hFFFF_FFFF : (q_neg ? -quo_step : quo_step);
        r_out <= div_zero ? raw_dividend  : (r_neg ? -rem_step : rem_step);
      end
    end
  end

  assign bus.busy      = (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = q_out;
  assign bus.remainder = r_out;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver queues expected results, a monitor
// pops them on done and checks that outputs hold steady between commits.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_at_edge = 1'b1;

  div_unit_if bus();

  div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    rst_at_edge = rst;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference results straight from integer arithmetic; wide signed math keeps
  // the most-negative / -1 case from overflowing.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  // Monitor: reset clears everything, done pops one expectation, otherwise hold.
  initial begin
    logic [31:0] held_q;
    logic [31:0] held_r;
    logic [63:0] e;
    logic        prev_done;
    held_q = 32'd0;
    held_r = 32'd0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        exp_q.delete();
        held_q = 32'd0;
        held_r = 32'd0;
        check_output("reset_busy", {31'b0, bus.busy}, 32'd0);
        check_output("reset_done", {31'b0, bus.done}, 32'd0);
        check_output("reset_quotient", bus.quotient, 32'd0);
        check_output("reset_remainder", bus.remainder, 32'd0);
      end else if (bus.done) begin
        check_output("busy_in_done", {31'b0, bus.busy}, 32'd0);
        check_output("done_width", {31'b0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          held_q = e[63:32];
          held_r = e[31:0];
          check_output("quotient", bus.quotient, held_q);
          check_output("remainder", bus.remainder, held_r);
        end
      end else begin
        check_output("hold_quotient", bus.quotient, held_q);
        check_output("hold_remainder", bus.remainder, held_r);
      end
      prev_done = bus.done;
    end
  end

  // Called at a negedge; returns at the negedge of the DONE cycle. A stray
  // 50/5 start is injected at edge E(ignore_at+1) when ignore_at >= 0.
  task automatic apply_stimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eq, input logic [31:0] er, input int ignore_at);
    int busy_cycles;
    int waited;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    exp_q.push_back({eq, er});
    @(negedge clk);
    bus.start = 1'b0;
    busy_cycles = 0;
    waited = 0;
    while (!bus.done && waited < 100) begin
      if (bus.busy) busy_cycles++;
      if (ignore_at >= 0 && waited == ignore_at) begin
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd50;
        bus.divisor   = 32'd5;
      end else if (ignore_at >= 0 && waited == ignore_at + 1) begin
        bus.start = 1'b0;
      end
      waited++;
      @(negedge clk);
    end
    check_output("done_seen", {31'b0, bus.done}, 32'd1);
    check_output("busy_cycles", 32'(busy_cycles), 32'd32);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] m;
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    apply_stimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, -1);
    @(negedge clk);
    apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, -1);
    @(negedge clk);
    apply_stimulus(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, -1);
    @(negedge clk);
    apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, -1);
    @(negedge clk);
    apply_stimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, -1);
    @(negedge clk);
    apply_stimulus(1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_04D2, -1);
    @(negedge clk);
    apply_stimulus(1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_04D2, -1);
    @(negedge clk);

    // Stray start mid-operation, then a back-to-back start in the DONE cycle.
    apply_stimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 9);
    apply_stimulus(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, -1);
    @(negedge clk);

    // Reset at E10 abandons the operation; the monitor flushes its expectation.
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    exp_q.push_back({32'd14, 32'd2});
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    apply_stimulus(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, -1);

    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = pick_operand();
      b = pick_operand();
      m = model(sgn, a, b);
      apply_stimulus(sgn, a, b, m[63:32], m[31:0], -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle 32-bit integer divider for the DIV/DIVU instructions of the pipelined CPU. Produces a quotient (LO) and a remainder (HI). These feed the execute-stage 4:1 result-select mux, alongside the ALU result and other sources. Uses one restoring-division step per cycle with a start/busy/done handshake, so the pipeline control stalls while `busy` is high.

## Interface
- No parameters; width is fixed at 32 bits.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset. Has priority over every other input.
- `start` input 1: request a division. Sampled on the rising edge.
- `is_signed` input 1: selects operation. 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `dividend` input 32: numerator. Sampled with `start`.
- `divisor` input 32: denominator. Sampled with `start`.
- `busy` output 1: high while an iteration is in progress.
- `done` output 1: one-cycle pulse when the results become valid.
- `quotient` output 32: LO result. Registered.
- `remainder` output 32: HI result. Registered.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: 32 iterations in progress.
  - DONE: single cycle, result announced.
- Start acceptance:
  - `start` is accepted in IDLE or DONE. It is ignored in CALC, with no effect on the in-flight operation.
- On acceptance:
  - Latch |dividend| and |divisor|. Magnitudes are used only when `is_signed`=1 and the operand MSB is 1; 0x80000000 maps to unsigned 0x80000000.
  - Latch the quotient sign (dividend MSB XOR divisor MSB, signed only) and the remainder sign (dividend MSB, signed only).
  - Latch raw `dividend` and a divide-by-zero flag.
  - Clear the iteration counter to 0 and go to CALC.
- CALC, each cycle (restoring step):
  - Shift partial remainder left by 1, bringing in the next dividend bit, MSB first.
  - Trial-subtract the divisor magnitude in 33-bit arithmetic.
  - If the result is non-negative, keep it and shift a 1 into the working quotient; otherwise shift a 0.
  - Counter increments each cycle. On the 32nd step (counter = 31), go to DONE.
- Result commit, on the same edge as the transition into DONE:
  - `quotient` = working quotient, negated if the quotient sign is set.
  - `remainder` = partial remainder, negated if the remainder sign is set.
- Divide by zero, overridden at commit for both signed and unsigned:
  - `quotient` = 0xFFFFFFFF.
  - `remainder` = the latched raw `dividend`.
  - Latency is unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): `quotient` = 0x80000000, `remainder` = 0. This falls out of the magnitude arithmetic; no special case is needed.
- Output holding:
  - `quotient`/`remainder` hold their values until the next commit.
  - They do not change during CALC, so a new operation does not disturb the previous result until its own DONE.
- DONE always goes to IDLE on the next edge, unless `start` is accepted there, in which case it goes to CALC.
- Reset:
  - `rst`=1 at any edge, including mid-CALC: go to IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, counter=0.
  - Any in-flight operation is abandoned and produces no `done`.
- Simultaneous `rst` and `start`: reset wins and the start is lost.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `quotient`=0x00000000, `remainder`=0x00000000.
- Latency, taking the accepting edge as E0:
  - `busy` is high for exactly 32 cycles, from after E0 until E32.
  - At E32, results are committed and `done` goes high for one cycle.
  - `busy` is low during the DONE cycle.
- Throughput:
  - A `start` sampled at E33 (the DONE cycle) is accepted, giving back-to-back operations every 33 cycles.
- `busy` and `done` are decoded from registered state. There is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, started at E0: `busy` high for 32 cycles, then `done` pulses for one cycle after E32 with `quotient`=14, `remainder`=2.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002) gives `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. The same operands with `is_signed`=0 give `quotient`=0x7FFFFFFC, `remainder`=1.
- Edge operands:
  - Signed 0x80000000 / 0xFFFFFFFF gives `quotient`=0x80000000, `remainder`=0.
  - Unsigned gives `quotient`=0, `remainder`=0x80000000.
  - 1234 / 0 in either mode gives `quotient`=0xFFFFFFFF, `remainder`=0x000004D2, with `done` still at E32.
- Handshake:
  - Pulse `start` with 50/5 at E10 while busy with 100/7: it is ignored and the result is 14/2.
  - Pulse `start` with 50/5 in the DONE cycle: it is accepted, and the next `done` occurs 33 cycles later with 10/0.
  - Across the whole second operation, `quotient`/`remainder` hold 14/2 until that commit.
- Reset mid-operation:
  - Assert `rst` at E10 of a 100/7 divide: from the next cycle `busy`=0, outputs are 0, and no `done` occurs.
  - A fresh `start` with 9/3 then completes normally with 3/0.
